// File: rtl/console_txarb.sv
// console_txarb: two-requester console character arbiter.
// Requester A (debug/hexbus) and requester B (CPU console) share one console
// transmitter. A grant is held for a whole line and released after the
// newline (7'h0a) is accepted. Ties in IDLE go round-robin.
// Optional feature: define CONSOLE_TXARB_TIMEOUT_EN to add an idle-release
// counter of LGTIMEOUT bits. With it, a grant whose owner has kept stb low for
// 2^LGTIMEOUT-1 cycles is dropped.
module console_txarb #(
  parameter int unsigned LGTIMEOUT = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_a_stb,
  input  logic [6:0] i_a_data,
  output logic       o_a_busy,
  input  logic       i_b_stb,
  input  logic [6:0] i_b_data,
  output logic       o_b_busy,
  output logic       o_console_stb,
  output logic [6:0] o_console_data,
  input  logic       i_console_busy,
  output logic [1:0] o_grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_b_q, last_b_d;   // 1: B was the most recent grantee
  logic   accept;
  logic   newline;
  logic   tmo_fire;

  // Grant encoding equals the state encoding, so o_grant comes straight from the register
  assign o_grant = state_q;

  // Steer the granted requester to the console; everyone else sees busy
  always_comb begin
    o_console_stb  = 1'b0;
    o_console_data = '0;
    o_a_busy       = 1'b1;
    o_b_busy       = 1'b1;
    unique case (state_q)
      GNT_A: begin
        o_console_stb  = i_a_stb;
        o_console_data = i_a_data;
        o_a_busy       = i_console_busy;
      end
      GNT_B: begin
        o_console_stb  = i_b_stb;
        o_console_data = i_b_data;
        o_b_busy       = i_console_busy;
      end
      default: ;
    endcase
  end

  assign accept  = o_console_stb && !i_console_busy;
  assign newline = accept && (o_console_data == 7'h0a);

`ifdef CONSOLE_TXARB_TIMEOUT_EN
  logic [LGTIMEOUT-1:0] tmo_q, tmo_d, tmo_inc;

  assign tmo_inc = tmo_q + LGTIMEOUT'(1);

  // Count granted cycles with the owner's stb low; fire when the count reaches all-ones
  always_comb begin
    tmo_d    = '0;
    tmo_fire = 1'b0;
    if (state_q != IDLE && !o_console_stb) begin
      if (&tmo_inc) begin
        tmo_fire = 1'b1;
      end else begin
        tmo_d = tmo_inc;
      end
    end
  end

  // Idle-release counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Arbitration and release decisions
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    unique case (state_q)
      IDLE: begin
        if (i_a_stb && i_b_stb) begin
          state_d = last_b_q ? GNT_A : GNT_B;
        end else if (i_a_stb) begin
          state_d = GNT_A;
        end else if (i_b_stb) begin
          state_d = GNT_B;
        end
        if (state_d != IDLE) begin
          last_b_d = (state_d == GNT_B);
        end
      end
      GNT_A, GNT_B: begin
        // Newline needs stb high and the timeout needs stb low, so they never coincide
        if (newline || tmo_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin history; reset favours A on the first tie
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
    end
  end

endmodule
